// File: rtl/clpoly_div.sv
// Iterative carry-less (GF(2) polynomial) divider.
// Produces Quot and Rem with A = clmul(Quot, B) xor Rem and deg(Rem) < deg(B),
// one quotient bit per clock, behind a Start/Busy/Done handshake.
// With W64 set (WIDTH=64 only) the low 32 bits of A and B are used and both
// results are sign-extended from bit 31.
module clpoly_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Flush,
  input  logic             W64,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Index of the highest set bit; zero when no bit is set.
  function automatic logic [CW-1:0] msb_index(input logic [WIDTH-1:0] v);
    logic [CW-1:0] idx;
    idx = {CW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) idx = CW'(i);
    end
    return idx;
  endfunction

  // Keep bits [31:0], clear everything above.
  function automatic logic [WIDTH-1:0] zext32(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = {WIDTH{1'b0}};
    r[31:0] = v[31:0];
    return r;
  endfunction

  // Replicate bit 31 into every bit above it.
  function automatic logic [WIDTH-1:0] sext32(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v;
    for (int i = 32; i < WIDTH; i++) begin
      r[i] = v[31];
    end
    return r;
  endfunction

  logic [1:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    d_r;
  logic             w64_r;
  logic [WIDTH-1:0] dividend_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] q_r;
  logic             busy_r;
  logic             done_r;
  logic             divzero_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;

  logic             w64_s;
  logic [WIDTH-1:0] a_eff_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [CW-1:0]    load_cnt_s;
  logic [WIDTH-1:0] t_s;
  logic [WIDTH-1:0] p_next_s;
  logic [WIDTH-1:0] q_next_s;
  logic             qbit_s;

  // Word-mode decode: W64 only has meaning in a 64-bit build.
  always_comb begin
    w64_s = 1'b0;
    if (WIDTH == 64) begin
      w64_s = W64;
    end else begin
      w64_s = 1'b0;
    end
    if (w64_s) begin
      a_eff_s    = zext32(A);
      b_eff_s    = zext32(B);
      load_cnt_s = CW'(31);
    end else begin
      a_eff_s    = A;
      b_eff_s    = B;
      load_cnt_s = CW'(WIDTH - 1);
    end
  end

  // One long-division step: bring down the next dividend bit, subtract
  // (xor) the divisor when the partial remainder reaches its degree.
  always_comb begin
    t_s = {p_r[WIDTH-2:0], dividend_r[cnt_r]};
    if (t_s[d_r]) begin
      p_next_s = t_s ^ divisor_r;
      qbit_s   = 1'b1;
    end else begin
      p_next_s = t_s;
      qbit_s   = 1'b0;
    end
    q_next_s = {q_r[WIDTH-2:0], qbit_s};
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      d_r        <= {CW{1'b0}};
      w64_r      <= 1'b0;
      dividend_r <= {WIDTH{1'b0}};
      divisor_r  <= {WIDTH{1'b0}};
      p_r        <= {WIDTH{1'b0}};
      q_r        <= {WIDTH{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      divzero_r  <= 1'b0;
      quot_r     <= {WIDTH{1'b0}};
      rem_r      <= {WIDTH{1'b0}};
    end else if (Flush) begin
      // Abort wins over both a new Start and a completing iteration.
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (Start) begin
            dividend_r <= a_eff_s;
            divisor_r  <= b_eff_s;
            d_r        <= msb_index(b_eff_s);
            w64_r      <= w64_s;
            p_r        <= {WIDTH{1'b0}};
            q_r        <= {WIDTH{1'b0}};
            cnt_r      <= load_cnt_s;
            if (b_eff_s == {WIDTH{1'b0}}) begin
              // Division by zero completes immediately.
              state_r   <= DONE;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
              divzero_r <= 1'b1;
              quot_r    <= {WIDTH{1'b0}};
              rem_r     <= w64_s ? sext32(a_eff_s) : a_eff_s;
            end else begin
              state_r   <= BUSY;
              busy_r    <= 1'b1;
              done_r    <= 1'b0;
              divzero_r <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        BUSY: begin
          // Start is deliberately not looked at here.
          p_r   <= p_next_s;
          q_r   <= q_next_s;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            quot_r  <= w64_r ? sext32(q_next_s) : q_next_s;
            rem_r   <= w64_r ? sext32(p_next_s) : p_next_s;
          end else begin
            state_r <= BUSY;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy    = busy_r;
  assign Done    = done_r;
  assign DivZero = divzero_r;
  assign Quot    = quot_r;
  assign Rem     = rem_r;

endmodule

// File: tb/tb_clpoly_div.sv
// Self-checking bench for clpoly_div (64-bit build, both word modes).
// Expected values come from a textbook polynomial long-division model.
module tb_clpoly_div;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        w64 = 1'b0;
  logic [63:0] a = 64'd0;
  logic [63:0] b = 64'd0;
  logic        busy, done, divzero;
  logic [63:0] quot, rem;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clpoly_div #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .Start(start), .Flush(flush), .W64(w64),
    .A(a), .B(b), .Busy(busy), .Done(done), .DivZero(divzero),
    .Quot(quot), .Rem(rem)
  );

  // Long division over GF(2): cancel leading terms of the dividend from the top.
  task automatic ref_div(input logic [63:0] av, input logic [63:0] bv, input logic wv,
                         output logic [63:0] q, output logic [63:0] r, output int lat);
    logic [63:0] ae, be;
    int db;
    ae = wv ? {32'd0, av[31:0]} : av;
    be = wv ? {32'd0, bv[31:0]} : bv;
    q = 64'd0;
    r = ae;
    if (be == 64'd0) begin
      lat = 0;
    end else begin
      lat = wv ? 32 : 64;
      db = 0;
      for (int i = 0; i < 64; i++) if (be[i]) db = i;
      for (int i = 63; i >= db; i--) begin
        if (r[i]) begin
          q[i-db] = 1'b1;
          r = r ^ (be << (i - db));
        end
      end
    end
    if (wv) begin
      q = {{32{q[31]}}, q[31:0]};
      r = {{32{r[31]}}, r[31:0]};
    end
  endtask

  function automatic logic [63:0] clmul(input logic [63:0] x, input logic [63:0] y);
    logic [63:0] p;
    p = 64'd0;
    for (int i = 0; i < 64; i++) if (x[i]) p = p ^ (y << i);
    return p;
  endfunction

  // Called at a negedge: present an op for one posedge, return at the next negedge.
  task automatic accept(input logic [63:0] av, input logic [63:0] bv, input logic wv);
    a = av; b = bv; w64 = wv; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles after the accept edge until Done, with a bound.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (divzero !== 1'b0) begin errors++; $display("FAIL reset_divzero got %b exp 0", divzero); end
    checks++; if (quot !== 64'd0) begin errors++; $display("FAIL reset_quot got %h exp 0", quot); end
    checks++; if (rem !== 64'd0) begin errors++; $display("FAIL reset_rem got %h exp 0", rem); end
    reset = 1'b0;
  endtask

  task automatic test_directed;
    logic [63:0] ta [7]; logic [63:0] tb_ [7]; logic tw [7];
    logic [63:0] eq [7]; logic [63:0] er [7]; int el [7];
    logic [63:0] mq, mr; int ml, lat, bc;
    ta[0] = 64'h57;                  tb_[0] = 64'h0B;  tw[0] = 1'b0; eq[0] = 64'h9;                 er[0] = 64'h4; el[0] = 64;
    ta[1] = 64'hDEADBEEF;            tb_[1] = 64'h1;   tw[1] = 1'b0; eq[1] = 64'hDEADBEEF;          er[1] = 64'h0; el[1] = 64;
    ta[2] = 64'h5;                   tb_[2] = 64'h100; tw[2] = 1'b0; eq[2] = 64'h0;                 er[2] = 64'h5; el[2] = 64;
    ta[3] = 64'hFFFFFFFF_80000001;   tb_[3] = 64'h1;   tw[3] = 1'b1; eq[3] = 64'hFFFFFFFF_80000001; er[3] = 64'h0; el[3] = 32;
    ta[4] = 64'h80000000_00000000;   tb_[4] = 64'h3;   tw[4] = 1'b0; eq[4] = 64'h7FFFFFFF_FFFFFFFF; er[4] = 64'h1; el[4] = 64;
    ta[5] = 64'h5;                   tb_[5] = 64'h100; tw[5] = 1'b1; eq[5] = 64'h0;                 er[5] = 64'h5; el[5] = 32;
    ta[6] = 64'h12345678_80000000;   tb_[6] = 64'hABCD_00000003; tw[6] = 1'b1; eq[6] = 64'h7FFFFFFF; er[6] = 64'h1; el[6] = 32;
    for (int i = 0; i < 7; i++) begin
      ref_div(ta[i], tb_[i], tw[i], mq, mr, ml);
      accept(ta[i], tb_[i], tw[i]);
      wait_done(lat, bc);
      checks++; if (lat !== el[i]) begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, el[i]); end
      checks++; if (bc !== el[i]) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d exp %0d", i, bc, el[i]); end
      checks++; if (quot !== eq[i] || quot !== mq) begin errors++; $display("FAIL dir%0d_quot got %h exp %h model %h", i, quot, eq[i], mq); end
      checks++; if (rem !== er[i] || rem !== mr) begin errors++; $display("FAIL dir%0d_rem got %h exp %h model %h", i, rem, er[i], mr); end
      checks++; if (divzero !== 1'b0) begin errors++; $display("FAIL dir%0d_divzero got %b exp 0", i, divzero); end
      @(posedge clk); @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got %b exp 0", i, done); end
    end
  endtask

  task automatic test_divzero;
    int lat, bc;
    accept(64'h1234, 64'h0, 1'b0);
    wait_done(lat, bc);
    checks++; if (lat !== 0) begin errors++; $display("FAIL dz_latency got %0d exp 0", lat); end
    checks++; if (divzero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b exp 1", divzero); end
    checks++; if (quot !== 64'd0) begin errors++; $display("FAIL dz_quot got %h exp 0", quot); end
    checks++; if (rem !== 64'h1234) begin errors++; $display("FAIL dz_rem got %h exp 1234", rem); end
    @(posedge clk); @(negedge clk);
    // Word mode: upper divisor bits are ignored, so this divisor is zero.
    accept(64'hABCD_80000001, 64'h5_00000000, 1'b1);
    wait_done(lat, bc);
    checks++; if (lat !== 0) begin errors++; $display("FAIL dz_w64_latency got %0d exp 0", lat); end
    checks++; if (divzero !== 1'b1) begin errors++; $display("FAIL dz_w64_flag got %b exp 1", divzero); end
    checks++; if (rem !== 64'hFFFFFFFF_80000001) begin errors++; $display("FAIL dz_w64_rem got %h exp ffffffff80000001", rem); end
    @(posedge clk); @(negedge clk);
    accept(64'h77, 64'h3, 1'b1);
    wait_done(lat, bc);
    checks++; if (divzero !== 1'b0) begin errors++; $display("FAIL dz_clear got %b exp 0", divzero); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_flush;
    logic [63:0] pq, pr; int dcnt;
    pq = quot; pr = rem;
    accept(64'hCAFE_F00D, 64'h1B, 1'b1);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    flush = 1'b1; start = 1'b1; a = 64'h99; b = 64'h7;
    @(posedge clk); @(negedge clk);
    flush = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done got %b exp 0", done); end
    checks++; if (quot !== pq) begin errors++; $display("FAIL flush_quot got %h exp %h", quot, pq); end
    checks++; if (rem !== pr) begin errors++; $display("FAIL flush_rem got %h exp %h", rem, pr); end
    dcnt = 0;
    repeat (80) begin @(posedge clk); @(negedge clk); if (done === 1'b1 || busy === 1'b1) dcnt++; end
    checks++; if (dcnt !== 0) begin errors++; $display("FAIL flush_quiet got %0d active cycles exp 0", dcnt); end
  endtask

  task automatic test_start_while_busy;
    logic [63:0] mq, mr; int ml, lat, bc, dcnt;
    ref_div(64'h1357_9BDF, 64'h11D, 1'b1, mq, mr, ml);
    accept(64'h1357_9BDF, 64'h11D, 1'b1);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    start = 1'b1; a = 64'hFFFF; b = 64'h0; w64 = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    checks++; if (lat + 4 !== ml) begin errors++; $display("FAIL sbusy_latency got %0d exp %0d", lat + 4, ml); end
    checks++; if (quot !== mq) begin errors++; $display("FAIL sbusy_quot got %h exp %h", quot, mq); end
    checks++; if (rem !== mr) begin errors++; $display("FAIL sbusy_rem got %h exp %h", rem, mr); end
    dcnt = 0;
    repeat (70) begin @(posedge clk); @(negedge clk); if (done === 1'b1) dcnt++; end
    checks++; if (dcnt !== 0) begin errors++; $display("FAIL sbusy_extra_done got %0d exp 0", dcnt); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] mq, mr; int ml, lat, bc;
    accept(64'hF0F0_1234, 64'h25, 1'b1);
    wait_done(lat, bc);
    ref_div(64'h0BAD_CAFE, 64'h1F, 1'b1, mq, mr, ml);
    accept(64'h0BAD_CAFE, 64'h1F, 1'b1);
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got done=%b busy=%b exp 0 1", done, busy); end
    wait_done(lat, bc);
    checks++; if (lat !== ml) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", lat, ml); end
    checks++; if (quot !== mq || rem !== mr) begin errors++; $display("FAIL b2b_result got %h/%h exp %h/%h", quot, rem, mq, mr); end
    accept(64'h42, 64'h0, 1'b0);
    checks++; if (done !== 1'b1 || rem !== 64'h42) begin errors++; $display("FAIL b2b_dz1 got done=%b rem=%h exp 1 42", done, rem); end
    accept(64'h43, 64'h0, 1'b0);
    checks++; if (done !== 1'b1 || rem !== 64'h43) begin errors++; $display("FAIL b2b_dz2 got done=%b rem=%h exp 1 43", done, rem); end
    @(posedge clk); @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_end got %b exp 0", done); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] mq, mr; int ml, lat, bc;
    accept(64'h1234_5678_9ABC_DEF0, 64'h3, 1'b0);
    repeat (5) begin @(posedge clk); @(negedge clk); end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || divzero !== 1'b0) begin errors++; $display("FAIL rstmid_flags got %b%b%b exp 000", busy, done, divzero); end
    checks++; if (quot !== 64'd0 || rem !== 64'd0) begin errors++; $display("FAIL rstmid_data got %h/%h exp 0/0", quot, rem); end
    ref_div(64'h600D, 64'h9, 1'b0, mq, mr, ml);
    accept(64'h600D, 64'h9, 1'b0);
    wait_done(lat, bc);
    checks++; if (quot !== mq || rem !== mr) begin errors++; $display("FAIL rstmid_recover got %h/%h exp %h/%h", quot, rem, mq, mr); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_random;
    logic [63:0] ra, rb, mq, mr, be, ae, lhs; logic rw; int ml, lat, bc;
    for (int n = 0; n < 300; n++) begin
      ra = {$urandom, $urandom};
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) rb = 64'd0;
      else rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      ref_div(ra, rb, rw, mq, mr, ml);
      accept(ra, rb, rw);
      wait_done(lat, bc);
      checks++; if (lat !== ml) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", n, lat, ml); end
      checks++; if (quot !== mq) begin errors++; $display("FAIL rnd%0d_quot got %h exp %h", n, quot, mq); end
      checks++; if (rem !== mr) begin errors++; $display("FAIL rnd%0d_rem got %h exp %h", n, rem, mr); end
      ae = rw ? {32'd0, ra[31:0]} : ra;
      be = rw ? {32'd0, rb[31:0]} : rb;
      if (be != 64'd0) begin
        lhs = rw ? (clmul({32'd0, quot[31:0]}, be) ^ {32'd0, rem[31:0]}) : (clmul(quot, be) ^ rem);
        checks++; if (lhs !== ae) begin errors++; $display("FAIL rnd%0d_identity got %h exp %h", n, lhs, ae); end
      end
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); @(negedge clk); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_divzero();
    test_flush();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clpoly_div.md
Name: clpoly_div

Overview:
- Iterative carry-less (GF(2) polynomial) divider: the inverse of the ZBC carry-less multiply.
- Given dividend A and divisor B, it produces quotient Q and remainder R such that A = clmul(Q,B) xor R, with deg(R) < deg(B).
- Sits beside the bit-manipulation ALU in the Execute stage as a multi-cycle unit. It uses a Start/Busy/Done handshake, in the same manner as the integer divider.
- One quotient bit is produced per cycle.

Parameters:
- WIDTH, 32, operand/result width; legal values 32 or 64.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- Start  input  1  request to begin a division; operands are sampled on the same edge
- Flush  input  1  abort any operation in progress
- W64  input  1  word op (only meaningful when WIDTH=64): use A[31:0], B[31:0]; sign-extend results from bit 31
- A  input  WIDTH  dividend polynomial (bit i = coefficient of x^i)
- B  input  WIDTH  divisor polynomial
- Busy  output  1  iteration in progress
- Done  output  1  one-cycle pulse: results are valid
- DivZero  output  1  last accepted op had B==0 (held with results)
- Quot  output  WIDTH  quotient
- Rem  output  WIDTH  remainder

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values: state IDLE, Busy=0, Done=0, DivZero=0, Quot=0, Rem=0, internal counter=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: Start → BUSY, or → DONE if the effective B==0.
  - BUSY: counter reaches 0 → DONE.
  - DONE: → IDLE, or directly → BUSY/DONE if Start is high that cycle (back-to-back ops allowed).
- Start is ignored while BUSY.
- Flush has priority over Start and over completion: from any state → IDLE at the next edge, with Done=0. Quot/Rem keep their previous values.
- reset mid-operation behaves like Flush and also clears the outputs.
- On accept, at edge k:
  - Latch the dividend (zero-extended from 32 bits if W64) and the divisor.
  - Compute d = index of the divisor MSB using a priority encoder; register it.
  - Clear partial remainder P and quotient Q.
  - Load counter = N-1, where N = 32 if W64 else WIDTH.
- Per BUSY cycle, processing dividend bit i from N-1 down to 0:
  - T = (P<<1) | a_i.
  - If T[d]==1: P ← T xor divisor, qbit=1; otherwise P ← T, qbit=0.
  - Q ← (Q<<1) | qbit.
  - Invariant: deg(P) < d, so WIDTH bits always suffice; no carry-out bit exists.
- Completion: Done is high exactly in the cycle following edge k+N; Busy is high for N cycles (edge k to edge k+N).
- Outputs on completion:
  - Quot = Q, Rem = P.
  - If W64: Quot = {32{Q[31]}, Q[31:0]} and Rem = {32{P[31]}, P[31:0]}.
- Outputs hold until the next accepted op or reset. Done is a single-cycle pulse.
- Divisor zero: edge k goes directly to DONE, so Done is high in the cycle after edge k. Quot=0, Rem=dividend (W64 rules applied), DivZero=1. DivZero clears on the next accept with a nonzero divisor.
- Divisor = 1 (d=0): Quot=A, Rem=0.
- Divisor degree greater than dividend degree: Quot=0, Rem=A.
- When WIDTH=32 the W64 input is ignored.
- Unused counter/priority-encoder bits are tied off; no latches.

Test Plan:
- WIDTH=8 bench variant (WIDTH legal range relaxed for unit test only): A=0x57, B=0x0B, Start pulse → Busy 8 cycles; Done in the cycle after edge k+8; Quot=0x09, Rem=0x04, DivZero=0.
- WIDTH=32: A=0xDEADBEEF, B=0x00000001 → Quot=0xDEADBEEF, Rem=0; then A=0x00000005, B=0x00000100 → Quot=0, Rem=0x5. Check A == clmul(Quot,B) xor Rem against a reference model for 10k random pairs.
- B=0 with A=0x1234 → Done in the cycle after the accept edge, DivZero=1, Quot=0, Rem=0x1234; the next op with B≠0 clears DivZero.
- WIDTH=64, W64=1: A=0xFFFFFFFF_80000001, B=0x1 → Quot=Rem sign-extended: Quot=0xFFFFFFFF_80000001, Rem=0, latency 32 cycles. Repeat with W64=0, A=0x80000000_00000000, B=0x3 → 64-cycle latency; verify the identity against the model.
- Flush asserted at BUSY cycle 5, with Start held the same cycle → IDLE next edge, no Done, Busy=0, Quot/Rem unchanged. Start while BUSY is ignored: the original result is returned.
- Back-to-back: Start high in the DONE cycle → new op accepted, with exactly one Done per op. Synchronous reset mid-BUSY → all outputs 0 at the next edge.
